// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the stream multiplexer/arbiter.
package stream_mux_pkg;

   typedef enum logic {ST_IDLE, ST_LOCKED} smux_state_t;

   localparam logic SEL_MODE_EXPLICIT = 1'b0;
   localparam logic SEL_MODE_RR       = 1'b1;

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Round-robin arbiter: rotate requests by ptr, pick the lowest set bit, rotate the index back.
module rr_arbiter #(
   parameter  int unsigned NUM_CH = 8,
   localparam int unsigned SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [SEL_W-1:0]  ptr_i,
   output logic [SEL_W-1:0]  gnt_idx_o,
   output logic              gnt_ok_o
);

   localparam int unsigned SUM_W = SEL_W + 1;

   logic [2*NUM_CH-1:0] req_dbl;
   logic [NUM_CH-1:0]   req_rot;
   logic [SEL_W-1:0]    off;
   logic [SUM_W-1:0]    sum;

   // Doubling the vector makes the right shift a rotate.
   assign req_dbl = {req_i, req_i};
   assign req_rot = NUM_CH'(req_dbl >> ptr_i);

   // Priority-encode the rotated requests, then add ptr back modulo NUM_CH.
   always_comb begin
      gnt_ok_o  = 1'b0;
      off       = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!gnt_ok_o && req_rot[i]) begin
            gnt_ok_o = 1'b1;
            off      = SEL_W'(i);
         end
      end
      sum = {1'b0, ptr_i} + {1'b0, off};
      if (sum >= SUM_W'(NUM_CH)) begin
         sum = sum - SUM_W'(NUM_CH);
      end
      gnt_idx_o = SEL_W'(sum);
   end

endmodule

// File: rtl/stream_mux_arb.sv
// NUM_CH valid/ready streams merged onto one registered output, grant locked per packet.
module stream_mux_arb
   import stream_mux_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = 16,
   parameter  int unsigned NUM_CH     = 8,
   localparam int unsigned SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         sel_mode_i,
   input  logic [SEL_W-1:0]             sel_i,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data_i,
   input  logic [NUM_CH-1:0]            in_valid_i,
   input  logic [NUM_CH-1:0]            in_last_i,
   output logic [NUM_CH-1:0]            in_ready_o,
   output logic [DATA_WIDTH-1:0]        out_data_o,
   output logic                         out_valid_o,
   output logic                         out_last_o,
   output logic [SEL_W-1:0]             out_ch_o,
   input  logic                         out_ready_i,
   output logic                         busy_o
);

   localparam int unsigned CNT_W = SEL_W + 1;

   smux_state_t           state_q;
   logic [SEL_W-1:0]      lock_ch_q;
   logic [SEL_W-1:0]      rr_ptr_q;
   logic                  busy_q;

   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;
   logic [SEL_W-1:0]      out_ch_q, out_ch_d;

   logic [SEL_W-1:0]      arb_idx;
   logic                  arb_ok;
   logic [SEL_W-1:0]      grant;
   logic                  grant_ok;
   logic                  load_en;
   logic                  accept;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_last;

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_rr_arbiter (
      .req_i     (in_valid_i),
      .ptr_i     (rr_ptr_q),
      .gnt_idx_o (arb_idx),
      .gnt_ok_o  (arb_ok)
   );

   assign load_en = !out_valid_q || out_ready_i;

   // Grant source: locked channel, else explicit sel or round-robin winner.
   always_comb begin
      grant    = '0;
      grant_ok = 1'b0;
      if (state_q == ST_LOCKED) begin
         grant    = lock_ch_q;
         grant_ok = 1'b1;
      end else if (NUM_CH == 1) begin
         grant    = '0;
         grant_ok = 1'b1;
      end else if (sel_mode_i == SEL_MODE_EXPLICIT) begin
         grant    = sel_i;
         grant_ok = ({1'b0, sel_i} < CNT_W'(NUM_CH));
      end else begin
         grant    = arb_idx;
         grant_ok = arb_ok;
      end
   end

   // One-hot ready plus beat select; out-of-range grants never match a channel.
   always_comb begin
      in_ready_o = '0;
      sel_data   = '0;
      sel_last   = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         in_ready_o[k] = !rst_i && load_en && grant_ok && (grant == SEL_W'(k));
         if (in_ready_o[k]) begin
            sel_data = in_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            sel_last = in_last_i[k];
         end
      end
   end

   assign accept = |(in_ready_o & in_valid_i);

   // Next output beat: reload when the stage is free, hold while stalled.
   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_ch_d    = out_ch_q;
      if (load_en) begin
         out_valid_d = accept;
         if (accept) begin
            out_data_d = sel_data;
            out_last_d = sel_last;
            out_ch_d   = grant;
         end
      end
   end

   // Output register stage.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_ch_q    <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_ch_q    <= out_ch_d;
      end
   end

   // Packet-lock FSM with lock channel, round-robin pointer and registered busy.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         lock_ch_q <= '0;
         rr_ptr_q  <= '0;
         busy_q    <= 1'b0;
      end else if (accept) begin
         if (sel_last) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            rr_ptr_q <= (grant == SEL_W'(NUM_CH - 1)) ? '0 : grant + SEL_W'(1);
         end else begin
            state_q   <= ST_LOCKED;
            busy_q    <= 1'b1;
            lock_ch_q <= grant;
         end
      end
   end

   assign out_data_o  = out_data_q;
   assign out_valid_o = out_valid_q;
   assign out_last_o  = out_last_q;
   assign out_ch_o    = out_ch_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed testbench for stream_mux_arb (8-channel main build, 6-channel build for invalid sel).
module tb_stream_mux_arb;

   logic         clk_i = 1'b0;
   logic         rst_i;

   // 8-channel DUT
   logic         sel_mode;
   logic [2:0]   sel;
   logic [127:0] in_data;
   logic [7:0]   in_valid;
   logic [7:0]   in_last;
   logic [7:0]   in_ready;
   logic [15:0]  out_data;
   logic         out_valid;
   logic         out_last;
   logic [2:0]   out_ch;
   logic         out_ready;
   logic         busy;

   // 6-channel DUT
   logic         sel_mode6;
   logic [2:0]   sel6;
   logic [95:0]  in_data6;
   logic [5:0]   in_valid6;
   logic [5:0]   in_last6;
   logic [5:0]   in_ready6;
   logic [15:0]  out_data6;
   logic         out_valid6;
   logic         out_last6;
   logic [2:0]   out_ch6;
   logic         out_ready6;
   logic         busy6;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   stream_mux_arb #(
      .DATA_WIDTH (16),
      .NUM_CH     (8)
   ) u_dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .sel_mode_i  (sel_mode),
      .sel_i       (sel),
      .in_data_i   (in_data),
      .in_valid_i  (in_valid),
      .in_last_i   (in_last),
      .in_ready_o  (in_ready),
      .out_data_o  (out_data),
      .out_valid_o (out_valid),
      .out_last_o  (out_last),
      .out_ch_o    (out_ch),
      .out_ready_i (out_ready),
      .busy_o      (busy)
   );

   stream_mux_arb #(
      .DATA_WIDTH (16),
      .NUM_CH     (6)
   ) u_dut6 (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .sel_mode_i  (sel_mode6),
      .sel_i       (sel6),
      .in_data_i   (in_data6),
      .in_valid_i  (in_valid6),
      .in_last_i   (in_last6),
      .in_ready_o  (in_ready6),
      .out_data_o  (out_data6),
      .out_valid_o (out_valid6),
      .out_last_o  (out_last6),
      .out_ch_o    (out_ch6),
      .out_ready_i (out_ready6),
      .busy_o      (busy6)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic [15:0] val);
      in_data[ch*16 +: 16] = val;
   endtask

   task automatic pulse_reset();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
   endtask

   initial begin
      rst_i      = 1'b1;
      sel_mode   = 1'b0;
      sel        = 3'd3;
      in_data    = '0;
      in_valid   = 8'h08;
      in_last    = 8'hFF;
      out_ready  = 1'b1;
      sel_mode6  = 1'b0;
      sel6       = 3'd7;
      in_data6   = '0;
      in_valid6  = 6'h00;
      in_last6   = 6'h3F;
      out_ready6 = 1'b1;

      // Reset state, with a grantable request pending
      tick();
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_data", 32'(out_data), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_in_ready", 32'(in_ready), 32'h00);
      rst_i = 1'b0;

      // 1. Explicit select of ch3
      set_ch(3, 16'hA5A5);
      #1;
      check_eq("t1_in_ready", 32'(in_ready), 32'h08);
      tick();
      in_valid = 8'h00;
      check_eq("t1_out_valid", 32'(out_valid), 32'd1);
      check_eq("t1_out_data", 32'(out_data), 32'hA5A5);
      check_eq("t1_out_ch", 32'(out_ch), 32'd3);
      check_eq("t1_out_last", 32'(out_last), 32'd1);

      // 2. Round-robin over all channels, single-beat packets
      pulse_reset();
      sel_mode = 1'b1;
      for (int k = 0; k < 8; k++) set_ch(k, 16'(k));
      in_last  = 8'hFF;
      in_valid = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         tick();
         check_eq($sformatf("t2_valid_%0d", i), 32'(out_valid), 32'd1);
         check_eq($sformatf("t2_ch_%0d", i), 32'(out_ch), 32'(i % 8));
         check_eq($sformatf("t2_data_%0d", i), 32'(out_data), 32'(i % 8));
      end
      in_valid = 8'h00;
      tick();
      check_eq("t2_idle_valid", 32'(out_valid), 32'd0);

      // 3. Packet lock: rr_ptr=1, ch2 sends 3 beats while ch5 waits
      set_ch(2, 16'h2000);
      set_ch(5, 16'h5555);
      in_last  = 8'b0010_0000;
      in_valid = 8'b0010_0100;
      tick();
      check_eq("t3_b0_ch", 32'(out_ch), 32'd2);
      check_eq("t3_b0_data", 32'(out_data), 32'h2000);
      check_eq("t3_b0_busy", 32'(busy), 32'd1);
      set_ch(2, 16'h2001);
      #1;
      check_eq("t3_lock_ready", 32'(in_ready), 32'h04);
      tick();
      check_eq("t3_b1_ch", 32'(out_ch), 32'd2);
      check_eq("t3_b1_data", 32'(out_data), 32'h2001);
      check_eq("t3_b1_busy", 32'(busy), 32'd1);
      set_ch(2, 16'h2002);
      in_last = 8'b0010_0100;
      tick();
      check_eq("t3_b2_ch", 32'(out_ch), 32'd2);
      check_eq("t3_b2_data", 32'(out_data), 32'h2002);
      check_eq("t3_b2_last", 32'(out_last), 32'd1);
      check_eq("t3_b2_busy", 32'(busy), 32'd0);
      in_valid = 8'b0010_0000;
      tick();
      check_eq("t3_next_ch", 32'(out_ch), 32'd5);
      check_eq("t3_next_data", 32'(out_data), 32'h5555);
      in_valid = 8'h00;

      // 4. Backpressure mid-packet on ch1 (explicit), sel change while locked ignored
      sel_mode = 1'b0;
      sel      = 3'd1;
      in_last  = 8'h00;
      in_valid = 8'h02;
      set_ch(1, 16'h1100);
      tick();
      check_eq("t4_b0_data", 32'(out_data), 32'h1100);
      out_ready = 1'b0;
      set_ch(1, 16'h1101);
      for (int i = 0; i < 4; i++) begin
         #1;
         check_eq($sformatf("t4_stall_ready_%0d", i), 32'(in_ready), 32'h00);
         tick();
         check_eq($sformatf("t4_stall_data_%0d", i), 32'(out_data), 32'h1100);
         check_eq($sformatf("t4_stall_valid_%0d", i), 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      tick();
      check_eq("t4_b1_data", 32'(out_data), 32'h1101);
      set_ch(1, 16'h1102);
      sel      = 3'd6;
      sel_mode = 1'b1;
      in_valid = 8'h42;
      #1;
      check_eq("t4_locked_ready", 32'(in_ready), 32'h02);
      tick();
      check_eq("t4_b2_data", 32'(out_data), 32'h1102);
      check_eq("t4_b2_ch", 32'(out_ch), 32'd1);
      set_ch(1, 16'h1103);
      in_last  = 8'h02;
      in_valid = 8'h02;
      tick();
      check_eq("t4_b3_data", 32'(out_data), 32'h1103);
      check_eq("t4_b3_last", 32'(out_last), 32'd1);
      check_eq("t4_b3_busy", 32'(busy), 32'd0);
      in_valid = 8'h00;

      // 5. Invalid select on the 6-channel build, then the top valid index
      sel6      = 3'd7;
      in_valid6 = 6'h3F;
      #1;
      check_eq("t5_bad_ready", 32'(in_ready6), 32'h00);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq($sformatf("t5_bad_valid_%0d", i), 32'(out_valid6), 32'd0);
      end
      sel6 = 3'd5;
      #1;
      check_eq("t5_edge_ready", 32'(in_ready6), 32'h20);
      in_valid6 = 6'h00;

      // 6. Reset while locked aborts the packet; RR restarts at ch0
      sel_mode = 1'b1;
      set_ch(4, 16'h4444);
      in_last  = 8'h00;
      in_valid = 8'h10;
      tick();
      check_eq("t6_pre_ch", 32'(out_ch), 32'd4);
      check_eq("t6_pre_busy", 32'(busy), 32'd1);
      rst_i = 1'b1;
      #1;
      check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
      check_eq("t6_rst_busy", 32'(busy), 32'd0);
      check_eq("t6_rst_ready", 32'(in_ready), 32'h00);
      tick();
      rst_i = 1'b0;
      for (int k = 0; k < 8; k++) set_ch(k, 16'(k));
      in_last  = 8'hFF;
      in_valid = 8'hFF;
      #1;
      check_eq("t6_rr_ready", 32'(in_ready), 32'h01);
      tick();
      check_eq("t6_rr_ch", 32'(out_ch), 32'd0);
      check_eq("t6_rr_busy", 32'(busy), 32'd0);
      in_valid = 8'h00;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
